fetch_stage: RTL and testbench

- Instruction-fetch stage of the 16-bit pipelined CPU; sits directly upstream of the opcode decoder/control unit.
- Owns the PC. Issues requests to the instruction memory over a valid/ready handshake that may take several cycles.
- Captures returned words into the IF/ID pipeline register; the decoder takes its opcode from if_id_instr[15:12].
- Handles branch redirect and flush, hazard stalls, and HLT freeze.

---
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 16-bit pipelined CPU.
//
// This stage owns the PC and fetches one 16-bit word at a time from the
// instruction memory over a valid/ready handshake. It loads each returned
// word into the IF/ID pipeline register. It also handles branch redirect
// and flush, hazard stalls, and the freeze caused by an HLT instruction.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   stall           - hazard hold; PC and IF/ID keep their values
//   branch_taken    - redirect to branch_target (bit 0 forced to 0) and flush IF/ID
//   branch_target   - redirect address
//   imem_req        - fetch request valid (FETCH state only)
//   imem_addr       - fetch address, always the current PC
//   imem_rdy        - memory returns imem_data this cycle
//   imem_data       - fetched instruction word
//   pc_curr         - current PC register
//   if_id_instr     - registered instruction for the decoder
//   if_id_pc_plus2  - registered PC+2 of that instruction
//   if_id_valid     - IF/ID holds a real instruction
//   halted          - fetch frozen by HLT
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] pc_curr,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcp2_q, pcp2_d;
    logic        valid_q, valid_d;
    logic [15:0] pc_plus2;

    // The add wraps modulo 2^16, so 16'hFFFE + 2 gives 16'h0000.
    assign pc_plus2 = pc_q + 16'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            pcp2_q  <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp2_q  <= pcp2_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp2_d  = pcp2_q;
        valid_d = valid_q;

        if (branch_taken) begin
            // A redirect wins in any state. It drops any word returned
            // this cycle and cancels a wrong-path HLT.
            state_d = FETCH;
            pc_d    = {branch_target[15:1], 1'b0};
            instr_d = 16'h0000;
            valid_d = 1'b0;
        end else if (stall) begin
            // Hold everything. A response that arrives now is dropped,
            // and the same PC is requested again on the next cycle.
        end else if (state_q == FETCH) begin
            if (imem_rdy) begin
                instr_d = imem_data;
                pcp2_d  = pc_plus2;
                valid_d = 1'b1;
                // The HLT word still enters IF/ID so that it drains down
                // the pipe. The PC stays on the HLT address.
                if (imem_data[15:12] == HLT_OPCODE)
                    state_d = HALT;
                else
                    pc_d = pc_plus2;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    assign imem_req       = (state_q == FETCH);
    assign imem_addr      = pc_q;
    assign pc_curr        = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus2 = pcp2_q;
    assign if_id_valid    = valid_q;
    assign halted         = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch_taken, imem_rdy;
    logic [15:0] branch_target, imem_data;
    logic        imem_req, if_id_valid, halted;
    logic [15:0] imem_addr, pc_curr, if_id_instr, if_id_pc_plus2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: the architectural view of the stage.
    logic [15:0] m_pc, m_instr, m_p2;
    logic        m_valid, m_halt;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data),
        .pc_curr(pc_curr), .if_id_instr(if_id_instr),
        .if_id_pc_plus2(if_id_pc_plus2), .if_id_valid(if_id_valid),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction memory contents. A few fixed words cover the directed
    // cases. Every other address gets a hashed word, and about 1 in 16 of
    // those is an HLT.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1123;
            16'h0002: return 16'h2456;
            16'h0010: return 16'h3010;
            16'h0020: return 16'h4020;
            16'h0030: return 16'hF000;
            16'hFFFE: return 16'h7ABC;
            default:  return {a[4:1] ^ a[8:5], a[11:0] ^ 12'h5A5};
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_p2 = 16'h0000;
        m_valid = 1'b0; m_halt = 1'b0;
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, "_req"},   {31'd0, imem_req},    {31'd0, ~m_halt});
        chk({ph, "_addr"},  {16'd0, imem_addr},   {16'd0, m_pc});
        chk({ph, "_pc"},    {16'd0, pc_curr},     {16'd0, m_pc});
        chk({ph, "_instr"}, {16'd0, if_id_instr}, {16'd0, m_instr});
        chk({ph, "_p2"},    {16'd0, if_id_pc_plus2}, {16'd0, m_p2});
        chk({ph, "_valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        chk({ph, "_halt"},  {31'd0, halted},      {31'd0, m_halt});
    endtask

    // Call this at a falling edge. It checks the current outputs, drives
    // one cycle of inputs, then steps the model across the rising edge.
    task automatic cycle(input logic st, input logic br, input logic [15:0] bt, input logic rdy);
        logic [15:0] w;
        check_outputs("cyc");
        w = mem_word(m_pc);
        stall = st; branch_taken = br; branch_target = bt;
        imem_rdy = rdy; imem_data = w;
        @(posedge clk);
        if (br) begin
            m_pc = bt & 16'hFFFE; m_valid = 1'b0; m_instr = 16'h0000; m_halt = 1'b0;
        end else if (st) begin
            // hold
        end else if (!m_halt && rdy) begin
            m_instr = w; m_p2 = m_pc + 16'd2; m_valid = 1'b1;
            if (w[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = m_pc + 16'd2;
        end else begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
        imem_rdy = 1'b0; imem_data = 16'h0;
        model_reset();
        @(negedge clk);
        check_outputs("rst");
        rst = 1'b0;

        // Back-to-back fetch with the memory always ready.
        cycle(0, 0, 16'h0, 1);
        chk("seq_instr0", {16'd0, if_id_instr}, 32'h1123);
        chk("seq_p2_0",   {16'd0, if_id_pc_plus2}, 32'h0002);
        chk("seq_addr1",  {16'd0, imem_addr}, 32'h0002);
        cycle(0, 0, 16'h0, 1);
        chk("seq_instr1", {16'd0, if_id_instr}, 32'h2456);
        chk("seq_p2_1",   {16'd0, if_id_pc_plus2}, 32'h0004);

        // The memory answers three cycles late on address 0x0010.
        cycle(0, 1, 16'h0010, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 16'h0, 0);
            chk("wait_addr", {16'd0, imem_addr}, 32'h0010);
            chk("wait_valid", {31'd0, if_id_valid}, 32'd0);
        end
        cycle(0, 0, 16'h0, 1);
        chk("wait_p2", {16'd0, if_id_pc_plus2}, 32'h0012);
        chk("wait_valid1", {31'd0, if_id_valid}, 32'd1);

        // A two-cycle stall at 0x0020 drops the returned word.
        cycle(0, 1, 16'h0020, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 16'h0, 1);
            chk("stall_pc", {16'd0, pc_curr}, 32'h0020);
            chk("stall_valid", {31'd0, if_id_valid}, 32'd0);
        end
        cycle(0, 0, 16'h0, 1);
        chk("stall_instr", {16'd0, if_id_instr}, 32'h4020);
        chk("stall_pc2", {16'd0, pc_curr}, 32'h0022);

        // A branch in the same cycle as a response: the word is dropped.
        cycle(0, 1, 16'h0041, 1);
        chk("br_pc", {16'd0, pc_curr}, 32'h0040);
        chk("br_valid", {31'd0, if_id_valid}, 32'd0);
        chk("br_instr", {16'd0, if_id_instr}, 32'h0000);

        // HLT at 0x0030, then a branch out to 0x0100.
        cycle(0, 1, 16'h0030, 0);
        cycle(0, 0, 16'h0, 1);
        chk("hlt_instr", {16'd0, if_id_instr}, 32'hF000);
        chk("hlt_pc", {16'd0, pc_curr}, 32'h0030);
        cycle(0, 0, 16'h0, 1);
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_req", {31'd0, imem_req}, 32'd0);
        chk("hlt_valid", {31'd0, if_id_valid}, 32'd0);
        cycle(0, 1, 16'h0100, 0);
        chk("unhlt_halted", {31'd0, halted}, 32'd0);
        chk("unhlt_addr", {16'd0, imem_addr}, 32'h0100);

        // The PC wraps from 0xFFFE to 0x0000.
        cycle(0, 1, 16'hFFFE, 0);
        cycle(0, 0, 16'h0, 1);
        chk("wrap_addr", {16'd0, imem_addr}, 32'h0000);
        chk("wrap_p2", {16'd0, if_id_pc_plus2}, 32'h0000);

        // Reset asserted in the middle of an outstanding request at 0x0202.
        cycle(0, 1, 16'h0200, 0);
        cycle(0, 0, 16'h0, 1);
        cycle(0, 0, 16'h0, 0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs("arst");
        @(negedge clk);
        rst = 1'b0;

        // Random traffic checked against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 6) == 0, ($urandom % 10) == 0,
                  16'($urandom), ($urandom % 3) != 0);
        end
        check_outputs("end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
